// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage pipeline with a multi-cycle HI/LO unit.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int unsigned MD_LATENCY  = 4,
  parameter logic [1:0]  DM2REG_LOAD = 2'b01,
  parameter int unsigned PERF_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             branch_d,
  input  logic             j_src_d,
  input  logic             mfhilo_d,
  input  logic             hilo_we_d,
  input  logic [4:0]       rse,
  input  logic [4:0]       rte,
  input  logic [4:0]       rf_wae,
  input  logic             we_rege,
  input  logic [1:0]       dm2rege,
  input  logic             hilo_wee,
  input  logic [4:0]       rf_wam,
  input  logic             we_regm,
  input  logic [1:0]       dm2regm,
  input  logic [4:0]       rf_waw,
  input  logic             we_regw,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  localparam int unsigned MdW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  logic lw_stall, br_stall, md_stall, stall;
  logic load_e, load_m;
  logic br_dep_e, br_dep_m;

  always_comb begin
    forward_ae = 2'b00;
    if (we_regm && reg_hit(rse, rf_wam))      forward_ae = 2'b10;
    else if (we_regw && reg_hit(rse, rf_waw)) forward_ae = 2'b01;

    forward_be = 2'b00;
    if (we_regm && reg_hit(rte, rf_wam))      forward_be = 2'b10;
    else if (we_regw && reg_hit(rte, rf_waw)) forward_be = 2'b01;

    forward_ad = we_regm && reg_hit(rs_d, rf_wam);
    forward_bd = we_regm && reg_hit(rt_d, rf_wam);
  end

  always_comb begin
    load_e   = we_rege && (dm2rege == DM2REG_LOAD);
    load_m   = we_regm && (dm2regm == DM2REG_LOAD);
    lw_stall = load_e && (reg_hit(rf_wae, rs_d) || reg_hit(rf_wae, rt_d));
    // Register jumps read only rs; branches compare both operands.
    br_dep_e = reg_hit(rf_wae, rs_d) || (branch_d && reg_hit(rf_wae, rt_d));
    br_dep_m = reg_hit(rf_wam, rs_d) || (branch_d && reg_hit(rf_wam, rt_d));
    br_stall = (branch_d || j_src_d) && ((we_rege && br_dep_e) || (load_m && br_dep_m));
    md_stall = md_busy && (mfhilo_d || hilo_we_d);
    stall    = !rst && (lw_stall || br_stall || md_stall);
    stall_f  = stall;
    stall_d  = stall;
    flush_e  = rst || stall;
  end

  if (MD_LATENCY > 1) begin : g_md
    localparam logic [MdW-1:0] MdReload = MdW'(MD_LATENCY - 1);

    logic [MdW-1:0] md_cnt_q, md_cnt_d;
    logic           md_busy_q;

    // A new HI/LO writer restarts the window even if one is still running.
    always_comb begin
      md_cnt_d = md_cnt_q;
      if (hilo_wee)              md_cnt_d = MdReload;
      else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        md_cnt_q  <= '0;
        md_busy_q <= 1'b0;
      end else begin
        md_cnt_q  <= md_cnt_d;
        md_busy_q <= (md_cnt_d != '0);
      end
    end

    assign md_busy = md_busy_q;
  end else begin : g_no_md
    assign md_busy = 1'b0;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_e && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized cycles against a
// rule-level reference model.
module tb_hazard_unit;

  localparam int         MdLat = 4;
  localparam logic [1:0] Load  = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rse, rte, rf_wae, rf_wam, rf_waw;
  logic       branch_d, j_src_d, mfhilo_d, hilo_we_d;
  logic       we_rege, hilo_wee, we_regm, we_regw;
  logic [1:0] dm2rege, dm2regm;
  logic       stall_f, stall_d, flush_e, forward_ad, forward_bd, md_busy;
  logic [1:0] forward_ae, forward_be;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int passed = 0;

  // Model state: edge counter and the edge at which the latest HI/LO writer started.
  int cyc = 0;
  int last_start = 0;
  bit have_start = 1'b0;

  logic [9:0] act;
  assign act = {stall_f, stall_d, flush_e, forward_ad, forward_bd, forward_ae, forward_be, md_busy};

  always #5 clk = ~clk;

  hazard_unit #(
    .MD_LATENCY (MdLat),
    .DM2REG_LOAD(Load),
    .PERF_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .branch_d  (branch_d),
    .j_src_d   (j_src_d),
    .mfhilo_d  (mfhilo_d),
    .hilo_we_d (hilo_we_d),
    .rse       (rse),
    .rte       (rte),
    .rf_wae    (rf_wae),
    .we_rege   (we_rege),
    .dm2rege   (dm2rege),
    .hilo_wee  (hilo_wee),
    .rf_wam    (rf_wam),
    .we_regm   (we_regm),
    .dm2regm   (dm2regm),
    .rf_waw    (rf_waw),
    .we_regw   (we_regw),
    .stall_f   (stall_f),
    .stall_d   (stall_d),
    .flush_e   (flush_e),
    .forward_ad(forward_ad),
    .forward_bd(forward_bd),
    .forward_ae(forward_ae),
    .forward_be(forward_be),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .md_busy   (md_busy)
  );

  function automatic bit model_busy();
    return have_start && ((cyc - last_start) < (MdLat - 1));
  endfunction

  // Forwarding source for an E operand: 2 = M stage, 1 = W stage, 0 = register file.
  function automatic logic [1:0] model_src(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (we_regm && rf_wam == r) return 2'd2;
    if (we_regw && rf_waw == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [9:0] model_out();
    bit busy   = model_busy();
    bit rs_e   = (rs_d != 0) && (rf_wae == rs_d);
    bit rt_e   = (rt_d != 0) && (rf_wae == rt_d);
    bit rs_m   = (rs_d != 0) && (rf_wam == rs_d);
    bit rt_m   = (rt_d != 0) && (rf_wam == rt_d);
    bit load_e = we_rege && (dm2rege == Load);
    bit load_m = we_regm && (dm2regm == Load);
    bit lw     = load_e && (rs_e || rt_e);
    bit br     = (branch_d || j_src_d) &&
                 ((we_rege && (rs_e || (branch_d && rt_e))) ||
                  (load_m && (rs_m || (branch_d && rt_m))));
    bit md     = busy && (mfhilo_d || hilo_we_d);
    bit st     = !rst && (lw || br || md);
    bit fad    = we_regm && rs_m;
    bit fbd    = we_regm && rt_m;
    return {st, st, rst || st, fad, fbd, model_src(rse), model_src(rte), busy};
  endfunction

  task automatic clear_inputs();
    {rs_d, rt_d, rse, rte, rf_wae, rf_wam, rf_waw} = '0;
    {branch_d, j_src_d, mfhilo_d, hilo_we_d, we_rege, hilo_wee, we_regm, we_regw} = '0;
    dm2rege = 2'b00;
    dm2regm = 2'b00;
  endtask

  task automatic tick();
    bit clr   = rst;
    bit start = !rst && hilo_wee;
    @(posedge clk);
    cyc++;
    if (clr) have_start = 1'b0;
    else if (start) begin
      have_start = 1'b1;
      last_start = cyc;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    hilo_wee = 1'b1;
    mfhilo_d = 1'b1;
    rse = 5'd4; rf_wam = 5'd4; we_regm = 1'b1;
    tick();
    tick();
    checks++;
    if ({stall_f, stall_d, flush_e, md_busy, forward_ae} !== 6'b001010)
      $display("FAIL reset_outputs: got %b required %b",
               {stall_f, stall_d, flush_e, md_busy, forward_ae}, 6'b001010);
    else passed++;
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (act !== model_out()) $display("FAIL reset_release: got %b required %b", act, model_out());
    else passed++;
  endtask

  task automatic test_forward();
    clear_inputs();
    rse = 5'd3; rf_wam = 5'd3; we_regm = 1'b1; rf_waw = 5'd3; we_regw = 1'b1;
    #1;
    checks++;
    if (forward_ae !== 2'b10) $display("FAIL fwd_m_priority: got %b required %b", forward_ae, 2'b10);
    else passed++;
    we_regm = 1'b0;
    #1;
    checks++;
    if (forward_ae !== 2'b01) $display("FAIL fwd_w: got %b required %b", forward_ae, 2'b01);
    else passed++;
    rse = 5'd0; rf_wam = 5'd0; rf_waw = 5'd0; we_regm = 1'b1;
    rte = 5'd9; rt_d = 5'd0;
    #1;
    checks++;
    if ({forward_ae, forward_be, forward_bd} !== 5'b00000)
      $display("FAIL fwd_r0: got %b required %b", {forward_ae, forward_be, forward_bd}, 5'b00000);
    else passed++;
    rf_waw = 5'd9; rs_d = 5'd6; rf_wam = 5'd6;
    #1;
    checks++;
    if (act !== model_out()) $display("FAIL fwd_mixed: got %b required %b", act, model_out());
    else passed++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    rs_d = 5'd2; rt_d = 5'd5;
    rf_wae = 5'd5; we_rege = 1'b1; dm2rege = Load;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111)
      $display("FAIL lw_stall: got %b required %b", {stall_f, stall_d, flush_e}, 3'b111);
    else passed++;
    tick();
    // Bubble in E, the load has moved to M while the consumer waits in D.
    rf_wae = 5'd0; we_rege = 1'b0; dm2rege = 2'b00;
    rf_wam = 5'd5; we_regm = 1'b1; dm2regm = Load;
    #1;
    checks++;
    if ({stall_f, flush_e} !== 2'b00 || act !== model_out())
      $display("FAIL lw_release: got %b required %b", act, model_out());
    else passed++;
    tick();
    rse = 5'd2; rte = 5'd5; rs_d = 5'd0; rt_d = 5'd0;
    rf_wam = 5'd0; we_regm = 1'b0; dm2regm = 2'b00;
    rf_waw = 5'd5; we_regw = 1'b1;
    #1;
    checks++;
    if (forward_be !== 2'b01) $display("FAIL lw_fwd_w: got %b required %b", forward_be, 2'b01);
    else passed++;
  endtask

  task automatic test_branch();
    int stalls = 0;
    clear_inputs();
    branch_d = 1'b1; rs_d = 5'd7; rt_d = 5'd1;
    rf_wae = 5'd7; we_rege = 1'b1;
    #1;
    checks++;
    if (stall_d !== 1'b1) $display("FAIL br_alu_stall: got %b required %b", stall_d, 1'b1);
    else passed++;
    tick();
    rf_wae = 5'd0; we_rege = 1'b0;
    rf_wam = 5'd7; we_regm = 1'b1;
    #1;
    checks++;
    if ({forward_ad, stall_d} !== 2'b10) $display("FAIL br_fwd_ad: got %b required %b", {forward_ad, stall_d}, 2'b10);
    else passed++;
    tick();
    // lw r7 feeding the branch: stalls while in E and again while in M.
    rf_wam = 5'd0; we_regm = 1'b0;
    rf_wae = 5'd7; we_rege = 1'b1; dm2rege = Load;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_d === 1'b1) stalls++;
      checks++;
      if (act !== model_out()) $display("FAIL br_lw_cycle%0d: got %b required %b", i, act, model_out());
      else passed++;
      tick();
      {rf_waw, we_regw} = {rf_wam, we_regm};
      {rf_wam, we_regm, dm2regm} = {rf_wae, we_rege, dm2rege};
      {rf_wae, we_rege, dm2rege} = '0;
    end
    checks++;
    if (stalls != 2) $display("FAIL br_lw_stalls: got %0d required %0d", stalls, 2);
    else passed++;
    clear_inputs();
    j_src_d = 1'b1; rs_d = 5'd8; rt_d = 5'd4; rf_wae = 5'd4; we_rege = 1'b1;
    #1;
    checks++;
    if (stall_d !== 1'b0) $display("FAIL jr_ignores_rt: got %b required %b", stall_d, 1'b0);
    else passed++;
  endtask

  task automatic test_md_window();
    int stalls = 0;
    clear_inputs();
    hilo_wee = 1'b1;
    tick();
    hilo_wee = 1'b0;
    mfhilo_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall_d === 1'b1 && md_busy === 1'b1) stalls++;
      checks++;
      if ({md_busy, stall_d} !== ((i < 3) ? 2'b11 : 2'b00))
        $display("FAIL md_cycle%0d: got %b required %b", i, {md_busy, stall_d}, (i < 3) ? 2'b11 : 2'b00);
      else passed++;
      tick();
    end
    checks++;
    if (stalls != 3) $display("FAIL md_stall_count: got %0d required %0d", stalls, 3);
    else passed++;
  endtask

  task automatic test_md_reload_reset();
    bit gap = 1'b0;
    clear_inputs();
    hilo_wee = 1'b1;
    tick();
    hilo_wee = 1'b0;
    tick();
    if (md_busy !== 1'b1) gap = 1'b1;
    tick();
    // Counter is at 1 here; restart the window on this edge.
    hilo_wee = 1'b1;
    if (md_busy !== 1'b1) gap = 1'b1;
    tick();
    hilo_wee = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (md_busy !== 1'b1) gap = 1'b1;
      tick();
    end
    checks++;
    if (gap || md_busy !== 1'b1) $display("FAIL md_reload_gap: got %b required %b", ~gap & md_busy, 1'b1);
    else passed++;
    rst = 1'b1;
    mfhilo_d = 1'b1;
    #1;
    checks++;
    if (act !== model_out()) $display("FAIL md_rst_hold: got %b required %b", act, model_out());
    else passed++;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({md_busy, stall_d, flush_e} !== 3'b000)
      $display("FAIL md_rst_abort: got %b required %b", {md_busy, stall_d, flush_e}, 3'b000);
    else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(31) == 0);
      rs_d      = 5'($urandom_range(3));
      rt_d      = 5'($urandom_range(3));
      rse       = 5'($urandom_range(3));
      rte       = 5'($urandom_range(3));
      rf_wae    = 5'($urandom_range(3));
      rf_wam    = 5'($urandom_range(3));
      rf_waw    = 5'($urandom_range(3));
      branch_d  = 1'($urandom_range(1));
      j_src_d   = ($urandom_range(3) == 0);
      mfhilo_d  = ($urandom_range(3) == 0);
      hilo_we_d = ($urandom_range(3) == 0);
      we_rege   = 1'($urandom_range(1));
      we_regm   = 1'($urandom_range(1));
      we_regw   = 1'($urandom_range(1));
      hilo_wee  = ($urandom_range(7) == 0);
      dm2rege   = 2'($urandom_range(3));
      dm2regm   = 2'($urandom_range(3));
      #1;
      checks++;
      if (act !== model_out()) begin
        if (bad < 10) $display("FAIL random_cycle%0d: got %b required %b", i, act, model_out());
        bad++;
      end else passed++;
      tick();
    end
    rst = 1'b0;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rt_d = 5'd5; rf_wae = 5'd5; we_rege = 1'b1; dm2rege = Load;
      tick();
      clear_inputs();
      tick();
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== {32'd5, 32'd5})
      $display("FAIL perf_counts: got %0d/%0d required 5/5", stall_cnt, flush_cnt);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({stall_cnt, flush_cnt} !== 64'd0)
      $display("FAIL perf_clear: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
    else passed++;
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_md_window();
    test_md_reload_reset();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
